// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the NES DMA arbiter: FSM states, per-cycle
// bus actions and the default register addresses.
package nes_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HALT  = 2'd1,
    ST_DUMMY = 2'd2,
    ST_RUN   = 2'd3
  } dma_state_t;

  // What the DMA does with the bus during the CPU cycle now in progress
  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_DMC_GET = 2'd1,
    ACT_OAM_GET = 2'd2,
    ACT_OAM_PUT = 2'd3
  } dma_act_t;

  localparam logic [15:0] OAM_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

endpackage

// File: rtl/nes_dma_arbiter.sv
// CPU-side DMA scheduler: halts the CPU and interleaves sprite OAM DMA and DMC
// sample fetches on the get/put phase grid, DMC first.
module nes_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] OAM_REG_ADDR  = OAM_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk,
  input  logic [15:0] a_in,
  input  logic [7:0]  from_cpu,
  input  logic        r_nw,
  input  logic [7:0]  from_mem,
  input  logic        dmc_req,
  input  logic [14:0] dmc_address,
  output logic        dmc_ack,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_r_nw,
  output logic [7:0]  dma_dout
);

  dma_state_t  r_state, w_state_nxt;
  dma_act_t    r_act, w_act_nxt;
  logic        r_put_phase;
  logic        r_oam_pend, w_oam_pend_nxt;
  logic [7:0]  r_page;
  logic [7:0]  r_idx, w_idx_nxt;
  logic        r_latched, w_latched_nxt;
  logic        r_dmc_served, w_dmc_served_nxt;
  logic        r_rdy, w_rdy_nxt;
  logic        r_dma_active, w_dma_active_nxt;
  logic [15:0] r_dma_addr, w_dma_addr_nxt;
  logic        r_dma_r_nw, w_dma_r_nw_nxt;
  logic [7:0]  r_dma_dout, w_dma_dout_nxt;
  logic        r_dmc_ack;
  logic        w_oam_trig, w_oam_done, w_dmc_live, w_get_nxt, w_schedule;

  // Retire the cycle that ends on this cpu_clk edge and update pending flags
  always_comb begin
    w_oam_trig       = !r_nw && (a_in == OAM_REG_ADDR) && !r_oam_pend;
    w_oam_done       = (r_act == ACT_OAM_PUT) && (r_idx == 8'hFF);
    w_oam_pend_nxt   = w_oam_trig || (r_oam_pend && !w_oam_done);
    // A request stays served until dmc_req drops, so a held request is not refetched
    w_dmc_served_nxt = (r_act == ACT_DMC_GET) || (r_dmc_served && dmc_req);
    w_dmc_live       = dmc_req && !r_dmc_served && (r_act != ACT_DMC_GET);
    w_get_nxt        = r_put_phase;
    w_idx_nxt        = r_idx;
    w_latched_nxt    = r_latched;
    w_dma_dout_nxt   = r_dma_dout;
    case (r_act)
      ACT_OAM_GET: begin
        w_latched_nxt  = 1'b1;
        w_dma_dout_nxt = from_mem;
      end
      ACT_OAM_PUT: begin
        w_latched_nxt = 1'b0;
        w_idx_nxt     = r_idx + 8'd1;
      end
      default: begin
        w_latched_nxt = r_latched;
      end
    endcase
  end

  // Next state and the bus action for the CPU cycle that starts on this edge
  always_comb begin
    w_state_nxt      = r_state;
    w_act_nxt        = ACT_NONE;
    w_rdy_nxt        = r_rdy;
    w_dma_active_nxt = r_dma_active;
    w_dma_addr_nxt   = r_dma_addr;
    w_dma_r_nw_nxt   = 1'b1;
    w_schedule       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_oam_pend_nxt || w_dmc_live) begin
          w_rdy_nxt   = 1'b0;
          w_state_nxt = ST_HALT;
        end else begin
          w_rdy_nxt = 1'b1;
        end
      end
      ST_HALT: begin
        // The 6502 only honours rdy on a read cycle
        if (r_nw) begin
          w_dma_active_nxt = 1'b1;
          w_dma_addr_nxt   = a_in;
          w_state_nxt      = ST_DUMMY;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_DUMMY: begin
        w_state_nxt = ST_RUN;
        w_schedule  = 1'b1;
      end
      ST_RUN: begin
        if (!w_oam_pend_nxt && !w_dmc_live) begin
          w_state_nxt      = ST_IDLE;
          w_rdy_nxt        = 1'b1;
          w_dma_active_nxt = 1'b0;
        end else begin
          w_schedule = 1'b1;
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_rdy_nxt        = 1'b1;
        w_dma_active_nxt = 1'b0;
      end
    endcase
    if (w_schedule && w_get_nxt && w_dmc_live) begin
      w_act_nxt      = ACT_DMC_GET;
      w_dma_addr_nxt = {1'b1, dmc_address};
    end else if (w_schedule && w_get_nxt && w_oam_pend_nxt && !w_latched_nxt) begin
      w_act_nxt      = ACT_OAM_GET;
      w_dma_addr_nxt = {r_page, w_idx_nxt};
    end else if (w_schedule && !w_get_nxt && w_latched_nxt) begin
      w_act_nxt      = ACT_OAM_PUT;
      w_dma_addr_nxt = OAM_DATA_ADDR;
      w_dma_r_nw_nxt = 1'b0;
    end else begin
      w_act_nxt = ACT_NONE;
    end
  end

  // CPU-cycle state and registered outputs; dmc_ack is a single-clk pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_act        <= ACT_NONE;
      r_put_phase  <= 1'b0;
      r_oam_pend   <= 1'b0;
      r_page       <= 8'h00;
      r_idx        <= 8'h00;
      r_latched    <= 1'b0;
      r_dmc_served <= 1'b0;
      r_rdy        <= 1'b1;
      r_dma_active <= 1'b0;
      r_dma_addr   <= 16'h0000;
      r_dma_r_nw   <= 1'b1;
      r_dma_dout   <= 8'h00;
      r_dmc_ack    <= 1'b0;
    end else begin
      r_dmc_ack <= cpu_clk && (r_act == ACT_DMC_GET);
      if (cpu_clk) begin
        r_state      <= w_state_nxt;
        r_act        <= w_act_nxt;
        r_put_phase  <= !r_put_phase;
        r_oam_pend   <= w_oam_pend_nxt;
        r_idx        <= w_idx_nxt;
        r_latched    <= w_latched_nxt;
        r_dmc_served <= w_dmc_served_nxt;
        r_rdy        <= w_rdy_nxt;
        r_dma_active <= w_dma_active_nxt;
        r_dma_addr   <= w_dma_addr_nxt;
        r_dma_r_nw   <= w_dma_r_nw_nxt;
        r_dma_dout   <= w_dma_dout_nxt;
        if (w_oam_trig) begin
          r_page <= from_cpu;
        end
      end
    end
  end

  assign dmc_ack    = r_dmc_ack;
  assign rdy        = r_rdy;
  assign dma_active = r_dma_active;
  assign dma_addr   = r_dma_addr;
  assign dma_r_nw   = r_dma_r_nw;
  assign dma_dout   = r_dma_dout;

endmodule
